// File: rtl/io_bus_hub.sv
// CPU-side hub: routes accesses to RAM or to NSLAVE req/ack IO channels,
// with a per-access watchdog and a sticky error/status register at IO slot 15.
module io_bus_hub #(
  parameter int unsigned NSLAVE    = 6,
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [3:0]  IO_NIBBLE = 4'hF,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          addr,
  input  logic [31:0]          datain,
  input  logic                 we,
  input  logic                 re,
  output logic [31:0]          dataout,
  output logic                 stall,
  input  logic [31:0]          memout,
  output logic                 wmem,
  output logic [NSLAVE-1:0]    s_sel,
  output logic [23:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic                 s_we,
  output logic                 s_re,
  input  logic [32*NSLAVE-1:0] s_rdata,
  input  logic [NSLAVE-1:0]    s_ack
);

  localparam int          CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]  NSLAVE_L = 5'(NSLAVE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wd_cnt;
  logic [3:0]       slot_q;
  logic             we_q, re_q;
  logic [31:0]      rdata_q;
  logic             err_timeout, err_unmapped;
  logic [3:0]       last_slot;
  logic [15:0]      err_count;

  logic        io, acc, mapped, status_sel, unmapped, start;
  logic [3:0]  slot;
  logic        ack_hit, to_hit, clear_status;
  logic [31:0] rdata_sel, status_word;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign io           = (addr[31:28] == IO_NIBBLE);
  assign slot         = addr[27:24];
  assign acc          = we | re;
  assign status_sel   = (slot == 4'hF);
  assign mapped       = ({1'b0, slot} < NSLAVE_L);
  assign unmapped     = io & ~mapped & ~status_sel;
  assign start        = io & acc & mapped;
  assign clear_status = io & status_sel & we & datain[0];
  assign to_hit       = (wd_cnt == CNT_LAST);
  assign status_word  = {err_timeout, err_unmapped, 10'b0, last_slot, err_count};

  assign s_addr  = addr[23:0];
  assign s_wdata = datain;
  assign wmem    = we & ~io;

  // Only the latched channel may complete the access; other acks are ignored.
  always_comb begin
    ack_hit   = 1'b0;
    rdata_sel = '0;
    s_sel     = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (slot_q == 4'(k)) begin
        ack_hit   = s_ack[k];
        rdata_sel = s_rdata[32*k +: 32];
        s_sel[k]  = (state == REQ);
      end
    end
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    s_we     = 1'b0;
    s_re     = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) state_nx = REQ;
      end
      REQ: begin
        stall = 1'b1;
        s_we  = we_q;
        s_re  = re_q;
        if (ack_hit || to_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The CPU is held in reset too, so never report a stall while reset is asserted.
    stall = stall & resetn;
  end

  always_comb begin
    dataout = '0;
    if (!io)
      dataout = memout;
    else if (status_sel)
      dataout = status_word;
    else if (mapped && state == DONE && re_q)
      dataout = rdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt  <= '0;
      slot_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          wd_cnt <= '0;
          slot_q <= slot;
          we_q   <= we;
          re_q   <= re;
        end
        REQ: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (ack_hit)     rdata_q <= rdata_sel;
          else if (to_hit) rdata_q <= ERR_DATA;
        end
        default: ;
      endcase
    end
  end

  // Error flags are sticky; a timeout and an unmapped access can never coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
      last_slot    <= '0;
      err_count    <= '0;
    end else if (clear_status) begin
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
      last_slot    <= '0;
      err_count    <= '0;
    end else if (state == REQ && !ack_hit && to_hit) begin
      err_timeout <= 1'b1;
      last_slot   <= slot_q;
      err_count   <= sat_inc16(err_count);
    end else if (unmapped && acc) begin
      err_unmapped <= 1'b1;
      last_slot    <= slot;
      err_count    <= sat_inc16(err_count);
    end
  end

endmodule

// File: tb/tb_io_bus_hub.sv
// Bench for io_bus_hub: directed scenarios plus randomized traffic checked
// against a transaction-level model of the status register and access timing.
module tb_io_bus_hub;

  localparam int NS  = 6;
  localparam int TO  = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   addr, datain, memout;
  logic          we, re;
  logic [31:0]   dataout;
  logic          stall, wmem, s_we, s_re;
  logic [NS-1:0] s_sel, s_ack;
  logic [23:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [32*NS-1:0] s_rdata;

  int checks = 0;
  int errors = 0;

  // Reference status register
  logic        m_et, m_eu;
  logic [3:0]  m_last;
  logic [15:0] m_cnt;

  io_bus_hub #(.NSLAVE(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .addr(addr), .datain(datain), .we(we), .re(re),
    .dataout(dataout), .stall(stall), .memout(memout), .wmem(wmem),
    .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_word();
    return {m_et, m_eu, 10'b0, m_last, m_cnt};
  endfunction

  task automatic m_reset();
    m_et = 0; m_eu = 0; m_last = 0; m_cnt = 0;
  endtask

  function automatic logic [15:0] m_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ram_access();
    logic wr;
    wr     = 1'($urandom);
    addr   = {4'($urandom_range(0, 14)), 28'($urandom)};
    datain = $urandom;
    memout = $urandom;
    we = wr; re = ~wr;
    #1;
    chk("ram_wmem", 32'(wmem), 32'(wr));
    chk("ram_stall", 32'(stall), 0);
    chk("ram_ssel", 32'(s_sel), 0);
    if (!wr) chk("ram_rdata", dataout, memout);
    step();
    we = 0; re = 0;
  endtask

  task automatic status_read();
    addr = {8'hFF, 24'($urandom)};
    re = 1; we = 0;
    #1;
    chk("status_stall", 32'(stall), 0);
    chk("status_word", dataout, m_word());
    step();
    re = 0;
  endtask

  task automatic status_write(input logic b);
    addr   = {8'hFF, 24'($urandom)};
    datain = {31'($urandom), b};
    we = 1; re = 0;
    #1;
    chk("statw_stall", 32'(stall), 0);
    step();
    we = 0;
    if (b) m_reset();
  endtask

  task automatic unmapped_access(input int slot);
    logic wr;
    wr   = 1'($urandom);
    addr = {4'hF, 4'(slot), 24'($urandom)};
    datain = $urandom;
    we = wr; re = ~wr;
    #1;
    chk("unm_stall", 32'(stall), 0);
    chk("unm_data", dataout, 0);
    chk("unm_ssel", 32'(s_sel), 0);
    chk("unm_wmem", 32'(wmem), 0);
    step();
    we = 0; re = 0;
    m_eu = 1; m_last = 4'(slot); m_cnt = m_inc(m_cnt);
  endtask

  // Mapped access; the slave acks in REQ wait-cycle w (w >= TO means too late).
  task automatic io_access(input int slot, input logic wr, input int w);
    logic [31:0]   data;
    logic [NS-1:0] oh;
    logic          tmo;
    int            ns;
    data = $urandom;
    oh   = NS'(1) << slot;
    tmo  = (w >= TO);
    ns   = tmo ? TO + 1 : w + 2;
    for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = $urandom;
    s_rdata[32*slot +: 32] = data;
    addr   = {4'hF, 4'(slot), 24'($urandom)};
    datain = $urandom;
    we = wr; re = ~wr;
    for (int c = 0; c <= ns; c++) begin
      s_ack = NS'($urandom) & ~oh;
      if (c == 0 || c == ns) s_ack = s_ack | (NS'($urandom) & oh);
      if (c == 1 + w) s_ack = s_ack | oh;
      #1;
      chk("io_stall", 32'(stall), 32'(c < ns));
      chk("io_ssel", 32'(s_sel), (c >= 1 && c < ns) ? 32'(oh) : 0);
      chk("io_swe", 32'(s_we), 32'((c >= 1 && c < ns) && wr));
      chk("io_sre", 32'(s_re), 32'((c >= 1 && c < ns) && !wr));
      if (c == 1) begin
        chk("io_saddr", 32'(s_addr), 32'(addr[23:0]));
        chk("io_swdata", s_wdata, datain);
      end
      if (c == ns) chk("io_done_data", dataout, wr ? 0 : (tmo ? ERRD : data));
      step();
    end
    we = 0; re = 0; s_ack = '0;
    if (tmo) begin
      m_et = 1; m_last = 4'(slot); m_cnt = m_inc(m_cnt);
    end
  endtask

  initial begin
    resetn = 0; addr = 0; datain = 0; we = 0; re = 0; memout = 0;
    s_ack = '0; s_rdata = '0;
    m_reset();
    step(); step();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ssel", 32'(s_sel), 0);
    chk("rst_swe", 32'(s_we), 0);
    chk("rst_sre", 32'(s_re), 0);
    resetn = 1;
    step();
    status_read();

    addr = 32'h00000010; we = 1; re = 0; datain = 32'h0BADF00D; memout = 32'hCAFEF00D;
    #1;
    chk("ram_w_wmem", 32'(wmem), 1);
    chk("ram_w_stall", 32'(stall), 0);
    chk("ram_w_ssel", 32'(s_sel), 0);
    step();
    we = 0; re = 1;
    #1;
    chk("ram_r_data", dataout, 32'hCAFEF00D);
    chk("ram_r_wmem", 32'(wmem), 0);
    step();
    re = 0;

    io_access(2, 1'b0, 3);
    status_read();
    io_access(1, 1'b1, TO + 5);
    status_read();
    chk("to_word_model", m_word(), 32'h8001_0001);
    status_write(1'b1);
    status_read();
    unmapped_access(9);
    status_read();
    status_write(1'b0);
    status_read();
    io_access(4, 1'b0, TO - 1);
    status_read();
    io_access(3, 1'b0, TO);
    status_read();

    // Reset while a slot-0 read is waiting in REQ
    status_write(1'b1);
    addr = 32'hF0000040; re = 1; we = 0; s_ack = '0;
    step(); step(); step();
    #2;
    resetn = 0;
    #1;
    chk("mid_rst_ssel", 32'(s_sel), 0);
    chk("mid_rst_sre", 32'(s_re), 0);
    re = 0;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    m_reset();
    step();
    resetn = 1;
    step();
    io_access(0, 1'b0, 1);
    status_read();

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0:       ram_access();
        1:       unmapped_access($urandom_range(NS, 14));
        2:       status_read();
        3:       status_write(1'($urandom_range(0, 3) == 0));
        default: io_access($urandom_range(0, NS - 1), 1'($urandom), $urandom_range(0, TO + 1));
      endcase
    end
    status_read();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
